// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states and access owner.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_DONE
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } arb_owner_t;

endpackage

// File: rtl/arb_latency_counter.sv
// Backend latency timer: cleared at grant, counts up to LATENCY and then holds.
module arb_latency_counter #(
   parameter int unsigned LATENCY = 4,
   localparam int unsigned CntW = $clog2(LATENCY + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            en_i,
   output logic [CntW-1:0] cnt_o,
   output logic            tc_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc_o  = (cnt_q == CntW'(LATENCY));
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one multi-cycle single-ported memory between fetch (I) and data (D) requesters.
// D wins ties, but I is forced after MAX_D_STREAK consecutive D grants while I waits.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned LATENCY      = 4,
   parameter int unsigned MAX_D_STREAK = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_done_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_stall_o,
   input  logic              d_req_i,
   input  logic              d_wr_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_done_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_stall_o,
   output logic              mem_en_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam int unsigned CntW = $clog2(LATENCY + 1);
   localparam int unsigned StrW = $clog2(MAX_D_STREAK + 1);

   arb_state_t        state_q, state_d;
   arb_owner_t        owner_q, owner_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [StrW-1:0]   streak_q, streak_d;

   logic            cnt_clr, cnt_en, cnt_tc;
   logic [CntW-1:0] cnt;
   logic            in_busy;
   logic            streak_full;

   arb_latency_counter #(
      .LATENCY (LATENCY)
   ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .cnt_o  (cnt),
      .tc_o   (cnt_tc)
   );

   assign streak_full = (streak_q == StrW'(MAX_D_STREAK));

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      streak_d   = streak_q;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (if_req_i || d_req_i) begin
               cnt_clr = 1'b1;
               state_d = ARB_BUSY;
               if (d_req_i && !(if_req_i && streak_full)) begin
                  owner_d = OWN_D;
                  wr_d    = d_wr_i;
                  addr_d  = d_addr_i;
                  wdata_d = d_wdata_i;
                  // Streak only measures how long a waiting I port has been passed over.
                  if (!if_req_i) begin
                     streak_d = '0;
                  end else if (!streak_full) begin
                     streak_d = streak_q + 1'b1;
                  end
               end else begin
                  owner_d  = OWN_I;
                  wr_d     = 1'b0;
                  addr_d   = if_addr_i;
                  wdata_d  = '0;
                  streak_d = '0;
               end
            end
         end
         ARB_BUSY: begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               state_d = ARB_DONE;
               if (!wr_q) begin
                  if (owner_q == OWN_D) begin
                     d_rdata_d = mem_rdata_i;
                  end else begin
                     if_rdata_d = mem_rdata_i;
                  end
               end
            end
         end
         ARB_DONE: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ARB_IDLE;
         owner_q    <= OWN_I;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         streak_q   <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         streak_q   <= streak_d;
      end
   end

   // Backend signals are driven only while an access is in flight, otherwise held at zero.
   assign in_busy     = (state_q == ARB_BUSY);
   assign mem_en_o    = in_busy && (cnt == '0);
   assign mem_wr_o    = in_busy && wr_q;
   assign mem_addr_o  = in_busy ? addr_q : '0;
   assign mem_wdata_o = in_busy ? wdata_q : '0;

   assign if_done_o  = (state_q == ARB_DONE) && (owner_q == OWN_I);
   assign d_done_o   = (state_q == ARB_DONE) && (owner_q == OWN_D);
   assign if_stall_o = if_req_i && !if_done_o;
   assign d_stall_o  = d_req_i && !d_done_o;
   assign if_rdata_o = if_rdata_q;
   assign d_rdata_o  = d_rdata_q;
   assign busy_o     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with LATENCY=4, MAX_D_STREAK=2.
module tb_unified_mem_arbiter;

   typedef struct packed {
      logic        rst_n;
      logic        if_req;
      logic [15:0] if_addr;
      logic        d_req;
      logic        d_wr;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic [15:0] mem_rdata;
   } in_t;

   typedef struct packed {
      logic        if_done;
      logic        if_stall;
      logic        d_done;
      logic        d_stall;
      logic        mem_en;
      logic        mem_wr;
      logic        busy;
      logic [15:0] mem_addr;
      logic [15:0] mem_wdata;
      logic [15:0] if_rdata;
      logic [15:0] d_rdata;
   } out_t;

   typedef struct {
      in_t  i;
      out_t e;
      int   txn;
      int   cyc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_wr;
   logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic        if_done, if_stall, d_done, d_stall, mem_en, mem_wr, busy;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[$];
   logic [15:0] m_if_rdata = '0;
   logic [15:0] m_d_rdata  = '0;
   int   n_txn = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(
      .ADDR_W       (16),
      .DATA_W       (16),
      .LATENCY      (4),
      .MAX_D_STREAK (2)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_done_o   (if_done),
      .if_rdata_o  (if_rdata),
      .if_stall_o  (if_stall),
      .d_req_i     (d_req),
      .d_wr_i      (d_wr),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_done_o    (d_done),
      .d_rdata_o   (d_rdata),
      .d_stall_o   (d_stall),
      .mem_en_o    (mem_en),
      .mem_wr_o    (mem_wr),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .busy_o      (busy)
   );

   function automatic out_t observe();
      out_t o;
      o.if_done   = if_done;
      o.if_stall  = if_stall;
      o.d_done    = d_done;
      o.d_stall   = d_stall;
      o.mem_en    = mem_en;
      o.mem_wr    = mem_wr;
      o.busy      = busy;
      o.mem_addr  = mem_addr;
      o.mem_wdata = mem_wdata;
      o.if_rdata  = if_rdata;
      o.d_rdata   = d_rdata;
      return o;
   endfunction

   task automatic apply(input in_t v);
      rst_n     = v.rst_n;
      if_req    = v.if_req;
      if_addr   = v.if_addr;
      d_req     = v.d_req;
      d_wr      = v.d_wr;
      d_addr    = v.d_addr;
      d_wdata   = v.d_wdata;
      mem_rdata = v.mem_rdata;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One 8-cycle transaction: request at cycle 0, done at cycle 6, idle at cycle 7.
   task automatic add_txn(input logic is_d, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata);
      for (int c = 0; c < 8; c++) begin
         vec_t v;
         logic req, act;
         v.i = '0;
         v.e = '0;
         req = (c <= 6);
         act = (c >= 1 && c <= 5);
         v.i.rst_n     = 1'b1;
         v.i.mem_rdata = (c == 5) ? rdata : 16'hDEAD;
         if (is_d) begin
            v.i.d_req   = req;
            v.i.d_wr    = wr;
            v.i.d_addr  = addr;
            v.i.d_wdata = wdata;
         end else begin
            v.i.if_req  = req;
            v.i.if_addr = addr;
         end
         if (c == 6 && !(is_d && wr)) begin
            if (is_d) m_d_rdata = rdata;
            else      m_if_rdata = rdata;
         end
         v.e.busy      = (c >= 1 && c <= 6);
         v.e.mem_en    = (c == 1);
         v.e.mem_wr    = act && is_d && wr;
         v.e.mem_addr  = act ? addr : 16'h0000;
         v.e.mem_wdata = (act && is_d) ? wdata : 16'h0000;
         v.e.if_rdata  = m_if_rdata;
         v.e.d_rdata   = m_d_rdata;
         if (is_d) begin
            v.e.d_done  = (c == 6);
            v.e.d_stall = (c <= 5);
         end else begin
            v.e.if_done  = (c == 6);
            v.e.if_stall = (c <= 5);
         end
         v.txn = n_txn;
         v.cyc = c;
         vecs.push_back(v);
      end
      n_txn++;
   endtask

   initial begin
      in_t idle;
      idle = '0;

      // Reset with idle inputs
      apply(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 128'(observe()), 128'(out_t'('0)));

      // I read, D write, D read
      add_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5);
      add_txn(1'b1, 1'b1, 16'h0200, 16'h1234, 16'hBEEF);
      add_txn(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h5A5A);
      foreach (vecs[k]) begin
         next_cycle();
         apply(vecs[k].i);
         @(negedge clk);
         chk($sformatf("txn%0d_cyc%0d", vecs[k].txn, vecs[k].cyc),
             128'(observe()), 128'(vecs[k].e));
      end

      // Both ports requesting continuously: D,D,I,D,D,I, one completion every 7 cycles
      begin
         int ndone;
         ndone = 0;
         next_cycle();
         apply(idle);
         rst_n = 1'b1; if_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
         if_addr = 16'h0100; d_addr = 16'h0400; mem_rdata = 16'h7777;
         for (int c = 0; c < 60 && ndone < 6; c++) begin
            @(negedge clk);
            if (d_done || if_done) begin
               logic exp_d;
               exp_d = (ndone % 3 != 2);
               chk($sformatf("arb_order_%0d", ndone), {96'(c), d_done, if_done},
                   {96'(6 + 7 * ndone), exp_d, !exp_d});
               ndone++;
            end
            if (ndone < 6) next_cycle();
         end
         if (ndone < 6) chk("arb_order_timeout", 128'(ndone), 128'(6));
         next_cycle();
         if_req = 1'b0; d_req = 1'b0;
         @(negedge clk);
         chk("arb_rdata_after", {if_rdata, d_rdata, busy}, {16'h7777, 16'h7777, 1'b0});
      end

      // Reset in the middle of a D read: no completion, read data cleared
      begin
         logic saw_done;
         saw_done = 1'b0;
         next_cycle();
         d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500; mem_rdata = 16'h1111;
         repeat (3) next_cycle();
         @(negedge clk);
         chk("rst_mid_busy_before", {busy, mem_en, d_rdata}, {1'b1, 1'b0, 16'h7777});
         rst_n = 1'b0;
         next_cycle();
         rst_n = 1'b1; d_req = 1'b0;
         @(negedge clk);
         chk("rst_mid_outputs", 128'(observe()), 128'(out_t'('0)));
         for (int c = 0; c < 8; c++) begin
            next_cycle();
            @(negedge clk);
            if (d_done || mem_en) saw_done = 1'b1;
         end
         chk("rst_mid_no_done", 128'(saw_done), 128'(0));
      end

      // Back-to-back I reads; address changes during BUSY must be ignored
      for (int c = 0; c <= 14; c++) begin
         next_cycle();
         mem_rdata = 16'hDEAD;
         case (c)
            0:  begin if_req = 1'b1; if_addr = 16'h0000; end
            2:  if_addr = 16'h0BAD;
            5:  mem_rdata = 16'h1357;
            7:  if_addr = 16'h0001;
            9:  if_addr = 16'h0F0F;
            12: mem_rdata = 16'h2468;
            14: if_req = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         case (c)
            1:  chk("b2b_grant0", {mem_en, mem_addr}, {1'b1, 16'h0000});
            3:  chk("b2b_addr0_hold", 128'(mem_addr), 128'(16'h0000));
            6:  chk("b2b_done0", {if_done, if_rdata}, {1'b1, 16'h1357});
            7:  chk("b2b_idle", {busy, if_done, mem_en, if_stall}, {4'b0001});
            8:  chk("b2b_grant1", {mem_en, mem_addr}, {1'b1, 16'h0001});
            10: chk("b2b_addr1_hold", 128'(mem_addr), 128'(16'h0001));
            13: chk("b2b_done1", {if_done, if_rdata}, {1'b1, 16'h2468});
            14: chk("b2b_end", {busy, if_done, if_stall}, {3'b000});
            default: ;
         endcase
      end

      // Reset while idle clears the read data registers
      next_cycle();
      apply(idle);
      repeat (2) next_cycle();
      @(negedge clk);
      chk("reset_idle_outputs", 128'(observe()), 128'(out_t'('0)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
